// File: rtl/vscale_if_stage.sv
// vscale_if_stage: instruction-fetch stage of the vscale 3-stage pipeline.
// Latency: fetch address is combinational; the fetched word lands in inst_DX one edge after rdata returns.
// Backpressure: stall_IF holds the fetch PC, stall_DX holds DX registers, imem_wait defers a pending redirect (REPLAY).
// Optional feature macro: VSCALE_IF_PERF_CNT_EN enables the fetch/redirect performance counters.
module vscale_if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0200,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  i_PC_src_sel,
    input  logic [31:0] i_branch_target,
    input  logic [31:0] i_jal_target,
    input  logic [31:0] i_reg_target,
    input  logic [31:0] i_stvec,
    input  logic        i_stall_IF,
    input  logic        i_kill_IF,
    input  logic        i_stall_DX,
    input  logic        i_imem_wait,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_imem_addr,
    output logic        o_imem_req,
    output logic [31:0] o_PC_IF,
    output logic [31:0] o_PC_DX,
    output logic [31:0] o_inst_DX,
    output logic [31:0] o_fetch_count,
    output logic [31:0] o_redirect_count
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_REPLAY = 2'd2
    } if_state_t;

    if_state_t   r_state;
    logic [31:0] r_pc_if;
    logic [31:0] r_pend_pc;
    logic [31:0] r_pc_dx;
    logic [31:0] r_inst_dx;

    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_imem_addr;
    logic        w_dx_upd;
    logic        w_dx_valid;

    // Decode the next-PC select into a redirect flag and its target (JALR target has bit 0 cleared).
    always_comb begin
        w_redirect = 1'b0;
        w_target   = 32'h0;
        case (i_PC_src_sel)
            3'd1: begin w_redirect = 1'b1; w_target = i_branch_target; end
            3'd2: begin w_redirect = 1'b1; w_target = i_jal_target; end
            3'd3: begin w_redirect = 1'b1; w_target = i_reg_target & 32'hFFFF_FFFE; end
            3'd4: begin w_redirect = 1'b1; w_target = i_stvec; end
            default: begin w_redirect = 1'b0; w_target = 32'h0; end
        endcase
    end

    // Fetch address: redirect beats stall_IF beats sequential; REPLAY re-presents the latched target.
    always_comb begin
        w_imem_addr = RESET_PC;
        if (!reset) begin
            case (r_state)
                ST_RUN: begin
                    if (w_redirect)      w_imem_addr = w_target;
                    else if (i_stall_IF) w_imem_addr = r_pc_if;
                    else                 w_imem_addr = r_pc_if + 32'd4;
                end
                ST_REPLAY: w_imem_addr = r_pend_pc;
                default:   w_imem_addr = RESET_PC;
            endcase
        end
    end

    assign o_imem_addr = w_imem_addr;
    assign o_imem_req  = ~reset;

    // Fetch FSM: tracks the IF PC and holds a redirect target across imem wait states.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_BOOT;
            r_pc_if   <= RESET_PC;
            r_pend_pc <= 32'h0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_pc_if <= RESET_PC;
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    r_pc_if <= w_imem_addr;
                    if (w_redirect && i_imem_wait) begin
                        r_pend_pc <= w_target;
                        r_state   <= ST_REPLAY;
                    end
                end
                ST_REPLAY: begin
                    if (!i_imem_wait) r_pc_if <= r_pend_pc;
                    // A fresh redirect replaces the pending target and keeps replaying it.
                    if (w_redirect)        r_pend_pc <= w_target;
                    else if (!i_imem_wait) r_state   <= ST_RUN;
                end
                default: r_state <= ST_BOOT;
            endcase
        end
    end

    assign w_dx_upd   = (r_state != ST_BOOT) && !i_stall_DX;
    assign w_dx_valid = (r_state == ST_RUN) && !i_kill_IF;

    // DX pipeline registers: take the IF instruction when valid, otherwise inject a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_dx   <= RESET_PC;
            r_inst_dx <= NOP_INST;
        end else if (w_dx_upd) begin
            r_pc_dx   <= r_pc_if;
            r_inst_dx <= w_dx_valid ? i_imem_rdata : NOP_INST;
        end
    end

    assign o_PC_IF   = r_pc_if;
    assign o_PC_DX   = r_pc_dx;
    assign o_inst_DX = r_inst_dx;

`ifdef VSCALE_IF_PERF_CNT_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_redirect_count;

    // Performance counters: delivered instructions and accepted redirects, both free-running.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_count    <= 32'h0;
            r_redirect_count <= 32'h0;
        end else begin
            if (w_dx_upd && w_dx_valid)              r_fetch_count    <= r_fetch_count + 32'd1;
            if (w_redirect && (r_state != ST_BOOT))  r_redirect_count <= r_redirect_count + 32'd1;
        end
    end

    assign o_fetch_count    = r_fetch_count;
    assign o_redirect_count = r_redirect_count;
`else
    assign o_fetch_count    = 32'h0;
    assign o_redirect_count = 32'h0;
`endif

endmodule

// File: doc/vscale_if_stage.md
# vscale_if_stage

Instruction-fetch stage for the vscale 3-stage pipeline. Sits upstream of the DX stage. Forms the next fetch address from the control unit's `PC_src_sel` and the datapath's redirect targets, and drives the instruction-memory request. Registers the fetched instruction and its PC into the DX pipeline registers (`inst_DX`, `PC_DX`). It obeys `stall_IF`/`kill_IF`/`stall_DX` from vscale_ctrl, and holds a pending redirect across imem wait states.

## Interface
- `RESET_PC`, default 32'h0000_0200: first fetch address after reset.
- `NOP_INST`, default 32'h0000_0013: bubble injected into DX (addi x0,x0,0).
- `clk  in  1`: clock.
- `reset  in  1`: reset, synchronous, active-high.
- `PC_src_sel  in  3`: next-PC select:
  - 0 = PLUS_FOUR
  - 1 = BRANCH_TARGET
  - 2 = JAL_TARGET
  - 3 = REG_TARGET
  - 4 = STVEC
  - 5–7 treated as PLUS_FOUR
- `branch_target  in  32`: branch target from DX.
- `jal_target  in  32`: JAL target from DX.
- `reg_target  in  32`: JALR target from DX; bit 0 is forced to 0 on use.
- `stvec  in  32`: trap vector.
- `stall_IF  in  1`: hold PC_IF.
- `kill_IF  in  1`: IF instruction must not enter DX as valid.
- `stall_DX  in  1`: hold DX registers.
- `imem_wait  in  1`: memory has not accepted/returned the current access.
- `imem_rdata  in  32`: instruction for PC_IF; valid when `!imem_wait`.
- `imem_addr  out  32`: fetch address presented this cycle.
- `imem_req  out  1`: fetch request valid.
- `PC_IF  out  32`: address of the instruction currently in IF.
- `PC_DX  out  32`: PC of `inst_DX`.
- `inst_DX  out  32`: instruction in DX.
- `fetch_count  out  32`: instructions delivered unkilled to DX.
- `redirect_count  out  32`: accepted non-sequential redirects.

## Operation
- Redirect is asserted when `PC_src_sel` ∈ {1,2,3,4}. Its target is the selected input.
- FSM states:
  - BOOT: one cycle after reset. `imem_addr`=`RESET_PC`, `imem_req`=1, no DX update.
  - RUN: normal fetch.
  - REPLAY: a redirect occurred while `imem_wait`=1.
- Transitions:
  - BOOT → RUN unconditionally.
  - RUN → REPLAY when redirect && `imem_wait`. The target is latched into `pend_pc`.
  - REPLAY → RUN when `!imem_wait`.
  - A new redirect in REPLAY overwrites `pend_pc` and the FSM stays in REPLAY.
- `imem_addr` in RUN (priority order):
  - redirect → target
  - `stall_IF` → `PC_IF`
  - otherwise `PC_IF`+4, modulo 2^32 (0xFFFF_FFFC+4 wraps to 0)
- `imem_addr` in REPLAY is `pend_pc`.
- `PC_IF` update:
  - BOOT: loads `RESET_PC`.
  - RUN: loads `imem_addr` every cycle.
  - REPLAY: holds until `!imem_wait`, then loads `pend_pc`.
- DX update, only when `!stall_DX`:
  - `PC_DX` ← `PC_IF`.
  - `inst_DX` ← `imem_rdata` if (state==RUN && `!kill_IF`), else `NOP_INST`.
- `imem_req` is 1 in every state except during reset.
- Redirect and `stall_IF` in the same cycle: redirect wins.
- STVEC has priority by encoding only; this block does no arbitration beyond `PC_src_sel`.

## Timing
- Reset values:
  - `PC_IF`=`RESET_PC`, `PC_DX`=`RESET_PC`, `inst_DX`=`NOP_INST`.
  - `pend_pc`=0, state=BOOT, both counters=0.
- During reset: `imem_addr`=`RESET_PC`, `imem_req`=0.
- Fetch latency: address presented in cycle N gives `imem_rdata` in N+1 (absent wait). The instruction reaches `inst_DX` at the edge ending N+1.
- Redirect penalty: one killed IF slot (kill driven by ctrl). The target is fetched in the redirect cycle.
- Reset asserted mid-REPLAY abandons `pend_pc` and returns to BOOT.
- `imem_addr` is combinational from registered state and DX-stage inputs. No combinational path from `imem_rdata`.

## Configuration
- `VSCALE_IF_PERF_CNT_EN` defined:
  - `fetch_count` increments on each DX update that loads a non-NOP-injected instruction.
  - `redirect_count` increments on each redirect cycle in RUN or REPLAY.
  - Both are 32-bit and wrap to 0.
- Undefined: both outputs are tied to 0 and no counter flops are built.

## Test plan
- Reset release, no waits: `imem_addr` sequence 0x200, 0x200, 0x204, 0x208. `inst_DX` stays NOP through BOOT, then the first fetched word appears one cycle after RUN entry.
- `PC_src_sel`=1, `branch_target`=0x400 in RUN: `imem_addr`=0x400 same cycle. `PC_IF`=0x400 next cycle. `redirect_count` increments by 1 (with macro).
- Redirect to 0x800 with `imem_wait`=1 for 3 cycles: FSM is in REPLAY and `imem_addr`=0x800 throughout. `PC_IF`=0x800 on the cycle after wait drops.
- `stall_DX`=1 for 2 cycles: `inst_DX`/`PC_DX` hold. `imem_addr`=`PC_IF` while `stall_IF`=1. `fetch_count` does not change.
- `kill_IF`=1 with valid `imem_rdata`=0x00500093: `inst_DX`=0x00000013 and `fetch_count` is unchanged.
- `PC_src_sel`=3, `reg_target`=0x1001: `imem_addr`=0x1000. `PC_IF` at 0xFFFF_FFFC with PLUS_FOUR gives next `imem_addr`=0x0.
